// File: rtl/usb_rx_deserializer_if.sv
// Line-sample inputs and packet-result outputs of the USB receive deserializer.
interface usb_rx_deserializer_if #(
  parameter int MAX_BITS = 100,
  parameter int CNT_W    = 32
);
  logic                DP;
  logic                DM;
  logic [MAX_BITS-1:0] pkt_out;
  logic [CNT_W-1:0]    pkt_len_out;
  logic                pkt_valid;
  logic                rx_error;
  logic                rx_active;

  modport master (
    output DP, DM,
    input  pkt_out, pkt_len_out, pkt_valid, rx_error, rx_active
  );

  modport slave (
    input  DP, DM,
    output pkt_out, pkt_len_out, pkt_valid, rx_error, rx_active
  );
endinterface

// File: rtl/usb_rx_deserializer.sv
// USB full-speed receive deserializer: SYNC detect, NRZI decode, unstuff, EOP detect.
// Optional CRC5/CRC16 residue check at end of packet when RX_CRC_CHECK_EN is defined.
module usb_rx_deserializer #(
  parameter int MAX_BITS = 100,
  parameter int CNT_W    = 32
) (
  input  logic                 clock,
  input  logic                 reset_n,
  usb_rx_deserializer_if.slave rx
);
  localparam int IDX_W = (MAX_BITS > 1) ? $clog2(MAX_BITS) : 1;

  typedef enum logic [1:0] {
    LINE_SE0 = 2'b00,
    LINE_K   = 2'b01,
    LINE_J   = 2'b10,
    LINE_SE1 = 2'b11
  } line_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SYNC,
    S_DATA,
    S_EOP1,
    S_EOP2,
    S_DONE,
    S_ERROR
  } state_e;

  state_e              state_q;
  logic                prev_j_q;
  logic [2:0]          sync_cnt_q;
  logic [2:0]          ones_q;
  logic [MAX_BITS-1:0] pkt_q;
  logic [CNT_W-1:0]    len_q;
  logic                valid_q;
  logic                error_q;
  logic                active_q;

  line_e               line_d;
  logic                is_jk_d;
  logic                bit_d;
  logic                full_d;
  logic [IDX_W-1:0]    idx_d;
  logic                crc_ok_d;

  always_comb begin
    line_d  = line_e'({rx.DP, rx.DM});
    is_jk_d = (line_d == LINE_J) || (line_d == LINE_K);
    bit_d   = ((line_d == LINE_J) == prev_j_q);
    full_d  = (len_q >= CNT_W'(MAX_BITS));
    idx_d   = len_q[IDX_W-1:0];
  end

`ifdef RX_CRC_CHECK_EN
  logic        store_d;
  logic        crc5_fb_d;
  logic        crc16_fb_d;
  logic [4:0]  crc5_q;
  logic [15:0] crc16_q;

  always_comb begin
    store_d    = (state_q == S_DATA) && is_jk_d && (ones_q != 3'd6) && !full_d;
    crc5_fb_d  = bit_d ^ crc5_q[4];
    crc16_fb_d = bit_d ^ crc16_q[15];
    unique case (pkt_q[1:0])
      2'b01:   crc_ok_d = (crc5_q == 5'b01100);
      2'b11:   crc_ok_d = (crc16_q == 16'h800D);
      default: crc_ok_d = 1'b1;
    endcase
  end

  // Residues cover everything after the PID/check byte, i.e. stored bits 8 and up.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      crc5_q  <= '1;
      crc16_q <= '1;
    end else if (state_q == S_SYNC) begin
      crc5_q  <= '1;
      crc16_q <= '1;
    end else if (store_d && (len_q >= CNT_W'(8))) begin
      crc5_q  <= {crc5_q[3:0], 1'b0} ^ (crc5_fb_d ? 5'b00101 : 5'b00000);
      crc16_q <= {crc16_q[14:0], 1'b0} ^ (crc16_fb_d ? 16'h8005 : 16'h0000);
    end
  end
`else
  always_comb begin
    crc_ok_d = 1'b1;
  end
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      prev_j_q   <= 1'b1;
      sync_cnt_q <= '0;
      ones_q     <= '0;
      pkt_q      <= '0;
      len_q      <= '0;
      valid_q    <= 1'b0;
      error_q    <= 1'b0;
      active_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      error_q <= 1'b0;
      if (is_jk_d) begin
        prev_j_q <= (line_d == LINE_J);
      end

      unique case (state_q)
        // DONE lasts one cycle but still accepts a K so back-to-back packets are not lost.
        S_IDLE, S_DONE: begin
          if (line_d == LINE_K) begin
            state_q    <= S_SYNC;
            sync_cnt_q <= 3'd1;
            pkt_q      <= '0;
            active_q   <= 1'b1;
          end else begin
            state_q <= S_IDLE;
          end
        end

        S_SYNC: begin
          if (line_d == LINE_SE1) begin
            error_q  <= 1'b1;
            active_q <= 1'b0;
            state_q  <= S_ERROR;
          end else if (!is_jk_d || (bit_d != (sync_cnt_q == 3'd7))) begin
            active_q <= 1'b0;
            state_q  <= S_IDLE;
          end else if (sync_cnt_q == 3'd7) begin
            ones_q  <= 3'd1;
            len_q   <= '0;
            state_q <= S_DATA;
          end else begin
            sync_cnt_q <= sync_cnt_q + 3'd1;
          end
        end

        S_DATA: begin
          if (line_d == LINE_SE1) begin
            error_q  <= 1'b1;
            active_q <= 1'b0;
            state_q  <= S_ERROR;
          end else if (line_d == LINE_SE0) begin
            state_q <= S_EOP1;
          end else if (ones_q == 3'd6) begin
            if (bit_d) begin
              error_q  <= 1'b1;
              active_q <= 1'b0;
              state_q  <= S_ERROR;
            end else begin
              ones_q <= '0;
            end
          end else if (full_d) begin
            error_q  <= 1'b1;
            active_q <= 1'b0;
            state_q  <= S_ERROR;
          end else begin
            pkt_q[idx_d] <= bit_d;
            len_q        <= len_q + CNT_W'(1);
            ones_q       <= bit_d ? (ones_q + 3'd1) : 3'd0;
          end
        end

        S_EOP1: begin
          if (line_d == LINE_SE0) begin
            state_q <= S_EOP2;
          end else begin
            error_q  <= 1'b1;
            active_q <= 1'b0;
            state_q  <= S_ERROR;
          end
        end

        S_EOP2: begin
          active_q <= 1'b0;
          if (line_d == LINE_J) begin
            state_q <= S_DONE;
            if (crc_ok_d) begin
              valid_q <= 1'b1;
            end else begin
              error_q <= 1'b1;
            end
          end else begin
            error_q <= 1'b1;
            state_q <= S_ERROR;
          end
        end

        S_ERROR: begin
          if (line_d == LINE_J) begin
            state_q <= S_IDLE;
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign rx.pkt_out     = pkt_q;
  assign rx.pkt_len_out = len_q;
  assign rx.pkt_valid   = valid_q;
  assign rx.rx_error    = error_q;
  assign rx.rx_active   = active_q;
endmodule

// File: tb/tb_usb_rx_deserializer.sv
// Scoreboard bench for usb_rx_deserializer: line-level packet encoder plus pulse monitor.
module tb_usb_rx_deserializer;
  localparam int MAX_BITS = 100;
  localparam int CNT_W    = 32;
  localparam logic [1:0] SYM_J   = 2'b10;
  localparam logic [1:0] SYM_K   = 2'b01;
  localparam logic [1:0] SYM_SE0 = 2'b00;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  usb_rx_deserializer_if #(.MAX_BITS(MAX_BITS), .CNT_W(CNT_W)) rx ();

  usb_rx_deserializer #(.MAX_BITS(MAX_BITS), .CNT_W(CNT_W)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .rx      (rx)
  );

  typedef struct {
    bit                  is_err;
    int                  len;
    logic [MAX_BITS-1:0] data;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;
  logic cur_j;

  function automatic void check(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endfunction

  // Monitor: every pulse must match the oldest outstanding expectation.
  always @(negedge clock) begin
    if (reset_n && (rx.pkt_valid || rx.rx_error)) begin
      check("pulse_exclusive", 128'(rx.pkt_valid & rx.rx_error), 128'(0));
      check("rx_active_at_pulse", 128'(rx.rx_active), 128'(0));
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse: valid=%0b error=%0b, required no pulse", rx.pkt_valid, rx.rx_error);
      end else begin
        mon_e = sb.pop_front();
        check("pulse_kind_is_error", 128'(rx.rx_error), 128'(mon_e.is_err));
        if (!mon_e.is_err) begin
          check("pkt_len_out", 128'(rx.pkt_len_out), 128'(mon_e.len));
          check("pkt_out", 128'(rx.pkt_out), 128'(mon_e.data));
        end
      end
    end
  end

  // Reference: a good packet reports its bits verbatim; a bad stuff bit or overflow reports an error.
  function automatic void expect_result(input logic [127:0] data, input int n, input bit is_err);
    exp_t e;
    e.is_err = is_err;
    e.len    = n;
    e.data   = '0;
    for (int i = 0; i < n && i < MAX_BITS; i++) e.data[i] = data[i];
    sb.push_back(e);
  endfunction

  task automatic send_sym(input logic [1:0] s);
    {rx.DP, rx.DM} = s;
    @(negedge clock);
  endtask

  task automatic nrzi(input bit b);
    if (!b) cur_j = ~cur_j;
    send_sym(cur_j ? SYM_J : SYM_K);
  endtask

  task automatic idle(input int n);
    cur_j = 1'b1;
    repeat (n) send_sym(SYM_J);
  endtask

  // mode 0: normal EOP; 1: first stuff bit sent as a non-transition; 2: stop after the last bit
  task automatic send_frame(input logic [127:0] data, input int n, input int mode);
    int ones;
    ones = 0;
    for (int i = 0; i < 8; i++) begin
      nrzi(i == 7);
      ones = (i == 7) ? 1 : 0;
    end
    check("rx_active_after_sync", 128'(rx.rx_active), 128'(1));
    for (int i = 0; i < n; i++) begin
      nrzi(data[i]);
      ones = data[i] ? ones + 1 : 0;
      if (ones == 6 && !(mode == 2 && i == n - 1)) begin
        if (mode == 1) begin
          nrzi(1'b1);
          return;
        end
        nrzi(1'b0);
        ones = 0;
      end
    end
    if (mode == 0) begin
      send_sym(SYM_SE0);
      send_sym(SYM_SE0);
      cur_j = 1'b1;
      send_sym(SYM_J);
    end
  endtask

  task automatic drain();
    int budget;
    budget = 20;
    while (sb.size() != 0 && budget > 0) begin
      @(negedge clock);
      budget--;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d expected pulses missing, required 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic rand_data(output logic [127:0] d, input bit ones_bias);
    for (int i = 0; i < 128; i++) d[i] = ones_bias ? ($urandom_range(0, 3) != 0) : 1'($urandom_range(0, 1));
  endtask

  task automatic good_packet(input logic [127:0] d, input int n);
    expect_result(d, n, 1'b0);
    send_frame(d, n, 0);
    idle(3);
    drain();
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_pkt_out"}, 128'(rx.pkt_out), 128'(0));
    check({tag, "_pkt_len_out"}, 128'(rx.pkt_len_out), 128'(0));
    check({tag, "_pkt_valid"}, 128'(rx.pkt_valid), 128'(0));
    check({tag, "_rx_error"}, 128'(rx.rx_error), 128'(0));
    check({tag, "_rx_active"}, 128'(rx.rx_active), 128'(0));
  endtask

  initial begin
    logic [127:0] d;
    int           n;
    rx.DP   = 1'b1;
    rx.DM   = 1'b0;
    cur_j   = 1'b1;
    reset_n = 1'b0;
    repeat (2) @(negedge clock);
    check_outputs_zero("reset");
    reset_n = 1'b1;
    idle(3);

    // Basic 24-bit packet, then one needing a stuffed bit
    good_packet(128'hA281E1, 24);
    good_packet(128'h01FE, 16);

    // Stuff bit that is not a transition aborts; next packet still decodes
    expect_result(128'h01FE, 16, 1'b1);
    send_frame(128'h01FE, 16, 1);
    idle(4);
    drain();
    good_packet(128'h01FE, 16);

    // Corrupted SYNC (KJKJJ): silent return to idle
    send_sym(SYM_K);
    send_sym(SYM_J);
    send_sym(SYM_K);
    send_sym(SYM_J);
    send_sym(SYM_J);
    idle(4);
    check("rx_active_after_bad_sync", 128'(rx.rx_active), 128'(0));
    drain();
    rand_data(d, 1'b0);
    good_packet(d, 32);

    // Zero-length and maximum-length packets
    good_packet(128'h0, 0);
    rand_data(d, 1'b1);
    good_packet(d, MAX_BITS);

    // Overflow on the 101st bit, then a 19-bit packet
    rand_data(d, 1'b0);
    expect_result(d, MAX_BITS + 1, 1'b1);
    send_frame(d, MAX_BITS + 1, 2);
    idle(4);
    drain();
    rand_data(d, 1'b0);
    good_packet(d, 19);

    // Random packets, biased toward long runs of ones
    for (int k = 0; k < 12; k++) begin
      rand_data(d, k[0]);
      n = $urandom_range(0, MAX_BITS);
      good_packet(d, n);
    end

    // Asynchronous reset mid-DATA
    send_frame(128'hFF0F, 12, 2);
    #2 reset_n = 1'b0;
    #1 check_outputs_zero("async_reset");
    @(negedge clock);
    cur_j = 1'b1;
    {rx.DP, rx.DM} = SYM_J;
    reset_n = 1'b1;
    idle(3);
    rand_data(d, 1'b1);
    good_packet(d, 20);

    idle(5);
    drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
